// File: rtl/reg_addr_pkg.sv
// rtl/reg_addr_pkg.sv - shared constants and helpers for the register-address pipeline
package reg_addr_pkg;

  localparam int ADDR_W_DEFAULT = 5;
  localparam int REG_X0         = 0;

  // Forwarding select width: enough to encode "none" plus stages 1..depth
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_addr_stage.sv
// rtl/reg_addr_stage.sv - one tracked stage holding {rd, valid, load}
module reg_addr_stage #(
  parameter int ADDR_W = 5
) (
  input  logic              reg_clk,
  input  logic              reg_rst_n,
  input  logic              shift,
  input  logic              flush,
  input  logic [ADDR_W-1:0] next_rd,
  input  logic              next_valid,
  input  logic              next_load,
  output logic [ADDR_W-1:0] rd,
  output logic              valid,
  output logic              load
);

  // Flush only kills the valid bit; address and load flag are left as they are
  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      rd    <= '0;
      valid <= 1'b0;
      load  <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (shift) begin
      rd    <= next_rd;
      valid <= next_valid;
      load  <= next_load;
    end
  end

endmodule

// File: rtl/reg_addr_pipeline.sv
// rtl/reg_addr_pipeline.sv - address latches, stage tracking, forwarding select and load-use detect
module reg_addr_pipeline
  import reg_addr_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int NUM_RD_PORTS = 2,
  parameter int DEPTH        = 3,
  parameter int SEL_W        = sel_width(DEPTH)
) (
  input  logic                           reg_clk,
  input  logic                           reg_rst_n,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0] rs_in,
  input  logic [NUM_RD_PORTS-1:0]        rs_wr_en,
  input  logic [ADDR_W-1:0]              rd_in,
  input  logic                           rd_wr_en,
  input  logic                           rd_we_in,
  input  logic                           is_load_in,
  input  logic                           advance,
  input  logic                           stall,
  input  logic                           flush,
  output logic [NUM_RD_PORTS*ADDR_W-1:0] rs_out,
  output logic [ADDR_W-1:0]              rd_out,
  output logic [DEPTH*ADDR_W-1:0]        stage_rd_out,
  output logic [DEPTH-1:0]               stage_valid,
  output logic [NUM_RD_PORTS*SEL_W-1:0]  fwd_sel,
  output logic                           load_use_hazard
);

  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_X0);

  logic [NUM_RD_PORTS*ADDR_W-1:0] rs_q;
  logic [ADDR_W-1:0]              rd_q;
  logic                           shift;

  logic [ADDR_W-1:0] st_rd      [DEPTH];
  logic [ADDR_W-1:0] st_next_rd [DEPTH];
  logic [DEPTH-1:0]  st_valid;
  logic [DEPTH-1:0]  st_load;
  logic [DEPTH-1:0]  st_next_valid;
  logic [DEPTH-1:0]  st_next_load;

  assign shift = advance & ~stall & ~flush;

  // Address latches capture on their enable and hold otherwise
  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      rs_q <= '0;
      rd_q <= '0;
    end else begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (rs_wr_en[p]) rs_q[p*ADDR_W +: ADDR_W] <= rs_in[p*ADDR_W +: ADDR_W];
      end
      if (rd_wr_en) rd_q <= rd_in;
    end
  end

  // Zero-latency bypass: an enabled port shows its live input
  always_comb begin
    rs_out = rs_q;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (rs_wr_en[p]) rs_out[p*ADDR_W +: ADDR_W] = rs_in[p*ADDR_W +: ADDR_W];
    end
    rd_out = rd_wr_en ? rd_in : rd_q;
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
        // Writes to x0 never produce a forwardable result
        assign st_next_rd[g]    = rd_out;
        assign st_next_valid[g] = rd_we_in & (rd_out != X0);
        assign st_next_load[g]  = is_load_in;
      end else begin : g_tail
        assign st_next_rd[g]    = st_rd[g-1];
        assign st_next_valid[g] = st_valid[g-1];
        assign st_next_load[g]  = st_load[g-1];
      end

      reg_addr_stage #(.ADDR_W(ADDR_W)) u_stage (
        .reg_clk    (reg_clk),
        .reg_rst_n  (reg_rst_n),
        .shift      (shift),
        .flush      (flush),
        .next_rd    (st_next_rd[g]),
        .next_valid (st_next_valid[g]),
        .next_load  (st_next_load[g]),
        .rd         (st_rd[g]),
        .valid      (st_valid[g]),
        .load       (st_load[g])
      );

      assign stage_rd_out[g*ADDR_W +: ADDR_W] = st_rd[g];
    end
  endgenerate

  assign stage_valid = st_valid;

  // Youngest matching stage wins: scan oldest to youngest so the last hit is the smallest k
  always_comb begin
    logic [ADDR_W-1:0] rs_p;
    fwd_sel         = '0;
    load_use_hazard = 1'b0;
    rs_p            = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rs_p = rs_out[p*ADDR_W +: ADDR_W];
      if (rs_p != X0) begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (st_valid[k] && (st_rd[k] == rs_p)) fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
        if (st_valid[0] && st_load[0] && (st_rd[0] == rs_p)) load_use_hazard = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_addr_pipeline.sv
// tb/tb_reg_addr_pipeline.sv - directed self-checking bench for reg_addr_pipeline
module tb_reg_addr_pipeline;

  localparam int ADDR_W = 5;
  localparam int NP     = 2;
  localparam int DEPTH  = 3;
  localparam int SEL_W  = 2;

  logic                    reg_clk;
  logic                    reg_rst_n;
  logic [NP*ADDR_W-1:0]    rs_in;
  logic [NP-1:0]           rs_wr_en;
  logic [ADDR_W-1:0]       rd_in;
  logic                    rd_wr_en;
  logic                    rd_we_in;
  logic                    is_load_in;
  logic                    advance;
  logic                    stall;
  logic                    flush;
  logic [NP*ADDR_W-1:0]    rs_out;
  logic [ADDR_W-1:0]       rd_out;
  logic [DEPTH*ADDR_W-1:0] stage_rd_out;
  logic [DEPTH-1:0]        stage_valid;
  logic [NP*SEL_W-1:0]     fwd_sel;
  logic                    load_use_hazard;

  int n_cmp;
  int n_bad;

  reg_addr_pipeline #(.ADDR_W(ADDR_W), .NUM_RD_PORTS(NP), .DEPTH(DEPTH)) dut (
    .reg_clk         (reg_clk),
    .reg_rst_n       (reg_rst_n),
    .rs_in           (rs_in),
    .rs_wr_en        (rs_wr_en),
    .rd_in           (rd_in),
    .rd_wr_en        (rd_wr_en),
    .rd_we_in        (rd_we_in),
    .is_load_in      (is_load_in),
    .advance         (advance),
    .stall           (stall),
    .flush           (flush),
    .rs_out          (rs_out),
    .rd_out          (rd_out),
    .stage_rd_out    (stage_rd_out),
    .stage_valid     (stage_valid),
    .fwd_sel         (fwd_sel),
    .load_use_hazard (load_use_hazard)
  );

  initial reg_clk = 1'b0;
  always #5 reg_clk = ~reg_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge reg_clk);
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reg_rst_n  = 1'b0;
    rs_in      = {5'd5, 5'd3};
    rs_wr_en   = 2'b11;
    rd_in      = 5'd0;
    rd_wr_en   = 1'b1;
    rd_we_in   = 1'b0;
    is_load_in = 1'b0;
    advance    = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    #3;
    chk("rst_bypass_rs", rs_out, {5'd5, 5'd3});
    chk("rst_valid", stage_valid, 3'b000);
    chk("rst_fwd", fwd_sel, 4'b0000);
    chk("rst_hazard", load_use_hazard, 1'b0);
    cyc();
    cyc();
    rs_wr_en  = 2'b00;
    rd_wr_en  = 1'b0;
    reg_rst_n = 1'b1;
    cyc();
    chk("post_rst_rs", rs_out, 10'd0);
    chk("post_rst_valid", stage_valid, 3'b000);
    chk("post_rst_fwd", fwd_sel, 4'b0000);

    // Forwarding distance tracks the stage as rd=7 moves down the pipe
    rd_in = 5'd7; rd_wr_en = 1'b1; rd_we_in = 1'b1; advance = 1'b1;
    cyc();
    rd_wr_en = 1'b0; rd_we_in = 1'b0; advance = 1'b0;
    rs_in = {5'd0, 5'd7}; rs_wr_en = 2'b01;
    #1;
    chk("rd7_s1_valid", stage_valid, 3'b001);
    chk("rd7_s1_fwd", fwd_sel, 4'b0001);
    advance = 1'b1;
    cyc();
    cyc();
    #1;
    chk("rd7_s3_valid", stage_valid, 3'b100);
    chk("rd7_s3_fwd", fwd_sel, 4'b0011);
    cyc();
    #1;
    chk("rd7_gone_fwd", fwd_sel, 4'b0000);
    chk("rd7_gone_valid", stage_valid, 3'b000);

    // Same rd in stages 1 and 2: youngest wins on both ports
    rd_in = 5'd9; rd_wr_en = 1'b1; rd_we_in = 1'b1; advance = 1'b1;
    cyc();
    cyc();
    advance = 1'b0; rd_wr_en = 1'b0; rd_we_in = 1'b0;
    rs_in = {5'd9, 5'd9}; rs_wr_en = 2'b11;
    #1;
    chk("rd9_valid", stage_valid, 3'b011);
    chk("rd9_fwd_both", fwd_sel, 4'b0101);
    chk("rd9_no_hazard", load_use_hazard, 1'b0);

    // Load in stage 1 with a dependent source: hazard holds across a stall
    rd_in = 5'd4; rd_wr_en = 1'b1; rd_we_in = 1'b1; is_load_in = 1'b1; advance = 1'b1;
    cyc();
    advance = 1'b0; rd_wr_en = 1'b0; rd_we_in = 1'b0; is_load_in = 1'b0;
    rs_in = {5'd4, 5'd0};
    #1;
    chk("ld_stage_rd", stage_rd_out, {5'd9, 5'd9, 5'd4});
    chk("ld_hazard", load_use_hazard, 1'b1);
    chk("ld_fwd", fwd_sel, 4'b0100);
    advance = 1'b1; stall = 1'b1;
    cyc();
    chk("stall_valid", stage_valid, 3'b111);
    chk("stall_stage_rd", stage_rd_out, {5'd9, 5'd9, 5'd4});
    chk("stall_hazard", load_use_hazard, 1'b1);
    stall = 1'b0;
    cyc();
    advance = 1'b0;
    #1;
    chk("unstall_hazard", load_use_hazard, 1'b0);
    chk("unstall_fwd", fwd_sel, 4'b1000);
    chk("unstall_valid", stage_valid, 3'b110);

    // rd=0 never becomes valid; flush beats advance and stall
    rd_in = 5'd0; rd_wr_en = 1'b1; rd_we_in = 1'b1; advance = 1'b1;
    cyc();
    rd_wr_en = 1'b0; rd_we_in = 1'b0; advance = 1'b0;
    rs_in = {5'd0, 5'd0};
    #1;
    chk("x0_valid", stage_valid, 3'b100);
    chk("x0_fwd", fwd_sel, 4'b0000);
    advance = 1'b1; stall = 1'b1; flush = 1'b1;
    cyc();
    advance = 1'b0; stall = 1'b0; flush = 1'b0;
    chk("flush_valid", stage_valid, 3'b000);
    chk("flush_keeps_rd", stage_rd_out, {5'd4, 5'd4, 5'd0});

    // Async reset between edges drops three valid load stages at once
    rd_wr_en = 1'b1; rd_we_in = 1'b1; is_load_in = 1'b1; advance = 1'b1;
    rd_in = 5'd1; cyc();
    rd_in = 5'd2; cyc();
    rd_in = 5'd3; cyc();
    rd_wr_en = 1'b0; rd_we_in = 1'b0; is_load_in = 1'b0; advance = 1'b0;
    rs_in = {5'd0, 5'd3}; rs_wr_en = 2'b01;
    #1;
    chk("fill_valid", stage_valid, 3'b111);
    chk("fill_hazard", load_use_hazard, 1'b1);
    #1;
    reg_rst_n = 1'b0;
    #1;
    chk("async_valid", stage_valid, 3'b000);
    chk("async_hazard", load_use_hazard, 1'b0);
    chk("async_fwd", fwd_sel, 4'b0000);
    chk("async_bypass", rs_out, {5'd0, 5'd3});
    rs_wr_en = 2'b00;
    cyc();
    reg_rst_n = 1'b1;
    cyc();
    chk("rerst_rs", rs_out, 10'd0);
    chk("rerst_rd", rd_out, 5'd0);
    chk("rerst_stage_rd", stage_rd_out, 15'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
